top_axis_multi_adder: RTL and testbench

TOP_AXIS_MULTI_ADDER -- requirements
Module: top_axis_multi_adder

---
 rtl/top_axis_adder_pkg.sv | 30 +++
 rtl/top_axis_pipe_stage.sv | 43 ++++
 rtl/top_axis_multi_adder.sv | 170 +++++++++++++++++
 tb/tb_top_axis_multi_adder.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_axis_adder_pkg.sv
// Shared constants and saturation helpers for the multi-input AXI-Stream lane adder.
// Saturation is only used when TOP_AXIS_MULTI_ADDER_SAT_EN is defined.
package top_axis_adder_pkg;

  localparam int DEF_TDATA_WIDTH = 512;
  localparam int DEF_ADDER_WIDTH = 32;
  localparam int DEF_NUM_INPUTS  = 4;
  localparam int DEF_PIPE_DEPTH  = 2;

  localparam int MIN_NUM_INPUTS = 2;
  localparam int MAX_NUM_INPUTS = 8;
  localparam int MIN_PIPE_DEPTH = 1;
  localparam int MAX_PIPE_DEPTH = 4;

  // Headroom for up to 8 inputs plus the constant without overflow.
  localparam int SAT_GUARD_BITS = 4;

  function automatic logic [63:0] sat_umax(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_smin(input int w);
    return ~sat_smax(w);
  endfunction

endpackage

// File: rtl/top_axis_pipe_stage.sv
// Single elastic valid/ready register stage; loads when empty or when its
// current content leaves in the same cycle.
module top_axis_pipe_stage #(
  parameter int WIDTH = 1
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  assign in_ready  = ~valid_r | out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Occupancy flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      valid_r <= 1'b0;
    end else if (in_ready) begin
      valid_r <= in_valid;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Payload register, no reset needed.
  always_ff @(posedge aclk) begin
    if (in_ready & in_valid) begin
      data_r <= in_data;
    end else begin
      data_r <= data_r;
    end
  end

endmodule

// File: rtl/top_axis_multi_adder.sv
// Joins N AXI-Stream inputs and adds them lane-wise plus a registered constant.
// Define TOP_AXIS_MULTI_ADDER_SAT_EN for saturating (unsigned/signed) lanes.
module top_axis_multi_adder
  import top_axis_adder_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int C_ADDER_BIT_WIDTH  = DEF_ADDER_WIDTH,
  parameter int C_NUM_INPUTS       = DEF_NUM_INPUTS,
  parameter int C_PIPE_DEPTH       = DEF_PIPE_DEPTH
) (
  input  logic                                        aclk,
  input  logic                                        areset,
  input  logic [C_ADDER_BIT_WIDTH-1:0]                ctrl_constant,
  input  logic                                        ctrl_signed,
  input  logic [C_NUM_INPUTS-1:0]                     s_axis_tvalid,
  output logic [C_NUM_INPUTS-1:0]                     s_axis_tready,
  input  logic [C_NUM_INPUTS*C_AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [C_NUM_INPUTS*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_NUM_INPUTS-1:0]                     s_axis_tlast,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]               m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]             m_axis_tkeep,
  output logic                                        m_axis_tlast,
  output logic [31:0]                                 stat_beat_count,
  output logic                                        stat_last_mismatch
);

  localparam int TW    = C_AXIS_TDATA_WIDTH;
  localparam int W     = C_ADDER_BIT_WIDTH;
  localparam int N     = C_NUM_INPUTS;
  localparam int D     = C_PIPE_DEPTH;
  localparam int LANES = TW / W;
  localparam int KW    = TW / 8;
  localparam int PW    = TW + KW + 1;

  logic [W-1:0]          const_r;
  logic                  all_valid;
  logic                  in_hs;
  logic                  lasts_equal;
  logic [KW-1:0]         keep_and;
  logic [TW-1:0]         sum_data;
  logic [D:0]            st_valid;
  logic [D:0]            st_ready;
  logic [D:0][PW-1:0]    st_data;
  logic [31:0]           beat_count_r;
  logic                  mismatch_r;

  // Constant is sampled every cycle; software holds it steady per stream.
  always_ff @(posedge aclk) begin
    const_r <= ctrl_constant;
  end

  assign all_valid     = &s_axis_tvalid;
  assign in_hs         = all_valid & st_ready[0] & ~areset;
  assign s_axis_tready = {N{in_hs}};
  assign lasts_equal   = (&s_axis_tlast) | ~(|s_axis_tlast);

  // Output keep is the intersection of all input keeps.
  always_comb begin
    keep_and = {KW{1'b1}};
    for (int i = 0; i < N; i++) begin
      keep_and = keep_and & s_axis_tkeep[i*KW +: KW];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef TOP_AXIS_MULTI_ADDER_SAT_EN
    localparam int          G      = SAT_GUARD_BITS;
    localparam int          EW     = W + G;
    localparam logic [63:0] UMAX64 = sat_umax(W);
    localparam logic [63:0] SMAX64 = sat_smax(W);
    localparam logic [63:0] SMIN64 = sat_smin(W);
    logic [EW-1:0] acc_u;
    logic [EW-1:0] acc_s;
    logic [W-1:0]  res;

    // Wide sums in both interpretations, then clamp per selected mode.
    always_comb begin
      acc_u = {{G{1'b0}}, const_r};
      acc_s = {{G{const_r[W-1]}}, const_r};
      for (int i = 0; i < N; i++) begin
        acc_u = acc_u + {{G{1'b0}}, s_axis_tdata[i*TW + l*W +: W]};
        acc_s = acc_s + {{G{s_axis_tdata[i*TW + l*W + W - 1]}}, s_axis_tdata[i*TW + l*W +: W]};
      end
      if (ctrl_signed) begin
        if ($signed(acc_s) > $signed(SMAX64[EW-1:0])) begin
          res = SMAX64[W-1:0];
        end else if ($signed(acc_s) < $signed(SMIN64[EW-1:0])) begin
          res = SMIN64[W-1:0];
        end else begin
          res = acc_s[W-1:0];
        end
      end else begin
        if (acc_u > UMAX64[EW-1:0]) begin
          res = UMAX64[W-1:0];
        end else begin
          res = acc_u[W-1:0];
        end
      end
    end
`else
    logic [W-1:0] res;

    // Modulo-2^W lane sum.
    always_comb begin
      res = const_r;
      for (int i = 0; i < N; i++) begin
        res = res + s_axis_tdata[i*TW + l*W +: W];
      end
    end
`endif
    assign sum_data[l*W +: W] = res;
  end

`ifndef TOP_AXIS_MULTI_ADDER_SAT_EN
  logic unused_ctrl_signed;
  assign unused_ctrl_signed = ctrl_signed;
`endif

  assign st_valid[0] = all_valid & ~areset;
  assign st_data[0]  = {sum_data, keep_and, s_axis_tlast[0]};
  assign st_ready[D] = m_axis_tready;

  for (genvar s = 0; s < D; s++) begin : g_stage
    top_axis_pipe_stage #(
      .WIDTH (PW)
    ) u_stage (
      .aclk      (aclk),
      .areset    (areset),
      .in_valid  (st_valid[s]),
      .in_ready  (st_ready[s]),
      .in_data   (st_data[s]),
      .out_valid (st_valid[s+1]),
      .out_ready (st_ready[s+1]),
      .out_data  (st_data[s+1])
    );
  end

  assign m_axis_tvalid = st_valid[D];
  assign m_axis_tdata  = st_data[D][PW-1:KW+1];
  assign m_axis_tkeep  = st_data[D][KW:1];
  assign m_axis_tlast  = st_data[D][0];

  // Downstream handshake counter, wraps naturally at 32 bits.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat_count_r <= 32'd0;
    end else if (m_axis_tvalid & m_axis_tready) begin
      beat_count_r <= beat_count_r + 32'd1;
    end else begin
      beat_count_r <= beat_count_r;
    end
  end

  // Sticky tlast disagreement flag, cleared only by reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mismatch_r <= 1'b0;
    end else if (in_hs & ~lasts_equal) begin
      mismatch_r <= 1'b1;
    end else begin
      mismatch_r <= mismatch_r;
    end
  end

  assign stat_beat_count    = beat_count_r;
  assign stat_last_mismatch = mismatch_r;

endmodule

// File: tb/tb_top_axis_multi_adder.sv
// Randomized self-checking bench for top_axis_multi_adder against a lane-arithmetic model.
module tb_top_axis_multi_adder;

  localparam int TW    = 512;
  localparam int W     = 32;
  localparam int N     = 4;
  localparam int D     = 2;
  localparam int LANES = TW / W;
  localparam int KW    = TW / 8;

  logic              aclk = 1'b0;
  logic              areset;
  logic [W-1:0]      ctrl_constant;
  logic              ctrl_signed;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tready;
  logic [N*TW-1:0]   s_tdata;
  logic [N*KW-1:0]   s_tkeep;
  logic [N-1:0]      s_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic [TW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic [31:0]       stat_beat_count;
  logic              stat_last_mismatch;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  top_axis_multi_adder #(
    .C_AXIS_TDATA_WIDTH (TW),
    .C_ADDER_BIT_WIDTH  (W),
    .C_NUM_INPUTS       (N),
    .C_PIPE_DEPTH       (D)
  ) dut (
    .aclk               (aclk),
    .areset             (areset),
    .ctrl_constant      (ctrl_constant),
    .ctrl_signed        (ctrl_signed),
    .s_axis_tvalid      (s_tvalid),
    .s_axis_tready      (s_tready),
    .s_axis_tdata       (s_tdata),
    .s_axis_tkeep       (s_tkeep),
    .s_axis_tlast       (s_tlast),
    .m_axis_tvalid      (m_tvalid),
    .m_axis_tready      (m_tready),
    .m_axis_tdata       (m_tdata),
    .m_axis_tkeep       (m_tkeep),
    .m_axis_tlast       (m_tlast),
    .stat_beat_count    (stat_beat_count),
    .stat_last_mismatch (stat_last_mismatch)
  );

  // Reference: per lane, integer sum of all inputs and the constant, then wrap or clamp.
  function automatic logic [TW-1:0] exp_sum(input logic [N*TW-1:0] d, input logic [W-1:0] k, input bit sgn);
    logic [TW-1:0] r;
    longint        acc;
    logic [W-1:0]  v;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      acc = sgn ? longint'($signed(k)) : longint'({32'd0, k});
      for (int i = 0; i < N; i++) begin
        v = d[i*TW + l*W +: W];
        acc = acc + (sgn ? longint'($signed(v)) : longint'({32'd0, v}));
      end
`ifdef TOP_AXIS_MULTI_ADDER_SAT_EN
      if (sgn) begin
        if (acc > longint'(32'h7FFF_FFFF)) acc = longint'(32'h7FFF_FFFF);
        else if (acc < -longint'(32'h8000_0000)) acc = -longint'(32'h8000_0000);
      end else if (acc > longint'(32'hFFFF_FFFF)) begin
        acc = longint'(32'hFFFF_FFFF);
      end
`endif
      r[l*W +: W] = acc[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [N*TW-1:0] fill_lanes(input logic [W-1:0] v0, input logic [W-1:0] v1,
                                                  input logic [W-1:0] v2, input logic [W-1:0] v3);
    logic [N*TW-1:0] d;
    logic [W-1:0]    v [N];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int i = 0; i < N; i++)
      for (int l = 0; l < LANES; l++)
        d[i*TW + l*W +: W] = v[i];
    return d;
  endfunction

  function automatic logic [TW-1:0] rep_lane(input logic [W-1:0] v);
    logic [TW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*W +: W] = v;
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge aclk);
    areset = 1'b1; s_tvalid = '0; m_tready = 1'b0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic set_constant(input logic [W-1:0] k, input bit sgn);
    @(negedge aclk);
    ctrl_constant = k; ctrl_signed = sgn;
    repeat (2) @(negedge aclk);
  endtask

  // Drives one joined beat with tready=1 and returns the first output beat and its latency.
  task automatic run_beat(input logic [N*TW-1:0] d, input logic [N*KW-1:0] kp, input logic [N-1:0] lst,
                          output logic [TW-1:0] od, output logic [KW-1:0] okp, output logic ol,
                          output int lat, output bit tmo);
    int n;
    tmo = 1'b0; lat = 0; n = 0;
    od = '0; okp = '0; ol = 1'b0;
    @(negedge aclk);
    s_tdata = d; s_tkeep = kp; s_tlast = lst; s_tvalid = '1; m_tready = 1'b1;
    #1;
    while (s_tready !== '1 && n < 50) begin
      @(negedge aclk); #1; n++;
    end
    if (n >= 50) begin
      tmo = 1'b1; s_tvalid = '0;
      return;
    end
    @(posedge aclk);
    @(negedge aclk);
    s_tvalid = '0; lat = 1;
    #1;
    while (m_tvalid !== 1'b1 && lat < 50) begin
      @(negedge aclk); #1; lat++;
    end
    if (lat >= 50) tmo = 1'b1;
    od = m_tdata; okp = m_tkeep; ol = m_tlast;
    @(posedge aclk);
  endtask

  task automatic test_reset();
    areset = 1'b1; s_tvalid = '1; m_tready = 1'b1;
    ctrl_constant = 32'd0; ctrl_signed = 1'b0;
    s_tdata = '0; s_tkeep = '1; s_tlast = '0;
    repeat (2) @(negedge aclk);
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_mvalid got=%b want=0", m_tvalid); end
    checks++; if (s_tready !== 4'h0) begin errors++; $display("FAIL reset_sready got=%h want=0", s_tready); end
    checks++; if (stat_beat_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", stat_beat_count); end
    checks++; if (stat_last_mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got=%b want=0", stat_last_mismatch); end
    @(negedge aclk);
    s_tvalid = '0; areset = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b want=0", m_tvalid); end
  endtask

  task automatic test_basic();
    logic [TW-1:0] od; logic [KW-1:0] okp; logic ol; int lat; bit tmo;
    logic [N*KW-1:0] kp;
    set_constant(32'd1, 1'b0);
    kp = '1;
    kp[2*KW +: KW] = {8'h00, {(KW-8){1'b1}}};
    run_beat(fill_lanes(32'd10, 32'd20, 32'd30, 32'd40), kp, 4'hF, od, okp, ol, lat, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL basic_timeout got=timeout want=beat"); end
    checks++; if (lat != D) begin errors++; $display("FAIL basic_latency got=%0d want=%0d", lat, D); end
    checks++; if (od !== rep_lane(32'd101)) begin errors++; $display("FAIL basic_sum got=%h want=all lanes 101", od); end
    checks++; if (okp !== {8'h00, {(KW-8){1'b1}}}) begin errors++; $display("FAIL basic_keep got=%h", okp); end
    checks++; if (ol !== 1'b1) begin errors++; $display("FAIL basic_last got=%b want=1", ol); end
  endtask

  task automatic test_join();
    int ins; int outs;
    ins = 0; outs = 0;
    @(negedge aclk);
    s_tdata = fill_lanes(32'd1, 32'd2, 32'd3, 32'd4); s_tkeep = '1; s_tlast = 4'h0;
    s_tvalid = 4'b0111; m_tready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (s_tready !== 4'h0) begin errors++; $display("FAIL join_sready cyc=%0d got=%h want=0", c, s_tready); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL join_mvalid cyc=%0d got=%b want=0", c, m_tvalid); end
      @(negedge aclk);
    end
    for (int c = 0; c < 10; c++) begin
      if (c == 0) s_tvalid = 4'hF;
      else if (ins > 0) s_tvalid = 4'h0;
      #1;
      if (s_tready === 4'hF) ins++;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) outs++;
      @(negedge aclk);
    end
    checks++; if (ins != 1) begin errors++; $display("FAIL join_inbeats got=%0d want=1", ins); end
    checks++; if (outs != 1) begin errors++; $display("FAIL join_outbeats got=%0d want=1", outs); end
  endtask

  task automatic test_corner();
    logic [TW-1:0] od; logic [KW-1:0] okp; logic ol; int lat; bit tmo;
    logic [W-1:0] want;
    set_constant(32'd0, 1'b0);
    run_beat(fill_lanes(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0), '1, 4'h0, od, okp, ol, lat, tmo);
`ifdef TOP_AXIS_MULTI_ADDER_SAT_EN
    want = 32'hFFFF_FFFF;
`else
    want = 32'h0000_0000;
`endif
    checks++; if (tmo || od !== rep_lane(want)) begin errors++; $display("FAIL unsigned_edge got=%h want lane=%h", od[W-1:0], want); end
    checks++; if (stat_last_mismatch !== 1'b0) begin errors++; $display("FAIL mismatch_clear got=%b want=0", stat_last_mismatch); end

    set_constant(32'd0, 1'b1);
    run_beat(fill_lanes(32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0), '1, 4'b1101, od, okp, ol, lat, tmo);
`ifdef TOP_AXIS_MULTI_ADDER_SAT_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'h8000_0000;
`endif
    checks++; if (tmo || od !== rep_lane(want)) begin errors++; $display("FAIL signed_pos_edge got=%h want lane=%h", od[W-1:0], want); end
    checks++; if (ol !== 1'b1) begin errors++; $display("FAIL last_from_input0 got=%b want=1", ol); end
    @(negedge aclk); #1;
    checks++; if (stat_last_mismatch !== 1'b1) begin errors++; $display("FAIL mismatch_set got=%b want=1", stat_last_mismatch); end

    run_beat(fill_lanes(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0), '1, 4'hF, od, okp, ol, lat, tmo);
`ifdef TOP_AXIS_MULTI_ADDER_SAT_EN
    want = 32'h8000_0000;
`else
    want = 32'h7FFF_FFFF;
`endif
    checks++; if (tmo || od !== rep_lane(want)) begin errors++; $display("FAIL signed_neg_edge got=%h want lane=%h", od[W-1:0], want); end
    checks++; if (stat_last_mismatch !== 1'b1) begin errors++; $display("FAIL mismatch_sticky got=%b want=1", stat_last_mismatch); end
  endtask

  task automatic test_stream();
    logic [TW-1:0] q_data[$];
    logic [KW-1:0] q_keep[$];
    logic          q_last[$];
    logic [TW-1:0] e_data, prev_data;
    logic [KW-1:0] e_keep, prev_keep;
    logic          prev_last, prev_stall, hs_in_prev;
    logic [W-1:0]  k;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0;
    prev_stall = 1'b0; hs_in_prev = 1'b0;
    prev_data = '0; prev_keep = '0; prev_last = 1'b0;
    apply_reset();
    k = $urandom;
    set_constant(k, 1'b0);
    while (recv < 64 && cyc < 3000) begin
      if (hs_in_prev) s_tvalid = '0;
      for (int i = 0; i < N; i++) begin
        if (!s_tvalid[i] && sent < 64 && $urandom_range(0, 9) < 7) begin
          s_tvalid[i] = 1'b1;
          for (int w = 0; w < LANES; w++) s_tdata[i*TW + w*W +: W] = $urandom;
          for (int w = 0; w < KW / 32; w++) s_tkeep[i*KW + w*32 +: 32] = $urandom;
          s_tlast[i] = (sent % 8 == 7);
        end
      end
      m_tready = ($urandom_range(0, 1) == 1);
      #1;
      if (prev_stall) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tkeep !== prev_keep || m_tlast !== prev_last) begin
          errors++; $display("FAIL stall_stable cyc=%0d valid=%b data_changed=%b", cyc, m_tvalid, m_tdata !== prev_data);
        end
      end
      if (q_data.size() == D && m_tready === 1'b0) begin
        checks++; if (s_tready !== 4'h0) begin errors++; $display("FAIL full_backpressure cyc=%0d got=%h want=0", cyc, s_tready); end
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        if (q_data.size() == 0) begin
          checks++; errors++; $display("FAIL stream_extra_beat cyc=%0d got=beat want=none", cyc);
        end else begin
          e_data = q_data.pop_front(); e_keep = q_keep.pop_front();
          checks++;
          if (m_tdata !== e_data || m_tkeep !== e_keep || m_tlast !== q_last.pop_front()) begin
            errors++; $display("FAIL stream_beat idx=%0d got=%h want=%h", recv, m_tdata[63:0], e_data[63:0]);
          end
        end
        recv++;
      end
      hs_in_prev = (s_tready === 4'hF);
      if (hs_in_prev) begin
        q_data.push_back(exp_sum(s_tdata, k, 1'b0));
        e_keep = '1;
        for (int i = 0; i < N; i++) e_keep = e_keep & s_tkeep[i*KW +: KW];
        q_keep.push_back(e_keep);
        q_last.push_back(s_tlast[0]);
        sent++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata; prev_keep = m_tkeep; prev_last = m_tlast;
      @(negedge aclk);
      cyc++;
    end
    s_tvalid = '0;
    checks++; if (recv != 64) begin errors++; $display("FAIL stream_received got=%0d want=64", recv); end
    #1;
    checks++; if (stat_beat_count !== 32'd64) begin errors++; $display("FAIL stream_count got=%0d want=64", stat_beat_count); end
    checks++; if (stat_last_mismatch !== 1'b0) begin errors++; $display("FAIL stream_mismatch got=%b want=0", stat_last_mismatch); end
  endtask

  task automatic test_reset_inflight();
    logic [N*TW-1:0] dc;
    logic [TW-1:0]   want, got;
    int outs;
    outs = 0; got = '0;
    set_constant(32'd5, 1'b0);
    m_tready = 1'b0; s_tkeep = '1; s_tlast = '0;
    s_tdata = fill_lanes(32'd1, 32'd1, 32'd1, 32'd1); s_tvalid = '1;
    @(negedge aclk);
    s_tdata = fill_lanes(32'd2, 32'd2, 32'd2, 32'd2);
    @(negedge aclk);
    s_tvalid = '0;
    #1;
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL inflight_loaded got=%b want=1", m_tvalid); end
    s_tvalid = '1; areset = 1'b1;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL inflight_flush got=%b want=0", m_tvalid); end
    checks++; if (s_tready !== 4'h0) begin errors++; $display("FAIL inflight_sready got=%h want=0", s_tready); end
    @(negedge aclk);
    dc = fill_lanes(32'd100, 32'd200, 32'd300, 32'd400);
    want = exp_sum(dc, 32'd5, 1'b0);
    areset = 1'b0; s_tdata = dc; m_tready = 1'b1;
    #1;
    checks++; if (s_tready !== 4'hF) begin errors++; $display("FAIL first_hs_after_reset got=%h want=f", s_tready); end
    @(negedge aclk);
    s_tvalid = '0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (m_tvalid === 1'b1) begin outs++; got = m_tdata; end
      @(negedge aclk);
    end
    checks++; if (outs != 1) begin errors++; $display("FAIL post_flush_beats got=%0d want=1", outs); end
    checks++; if (got !== want) begin errors++; $display("FAIL post_flush_data got=%h want=%h", got[63:0], want[63:0]); end
    checks++; if (stat_beat_count !== 32'd1) begin errors++; $display("FAIL post_flush_count got=%0d want=1", stat_beat_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_join();
    test_corner();
    test_stream();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
